sprite_fetch_arbiter: RTL and testbench

- Shares one sprite ROM read port between the player-1 and player-2 sprite address generators.
- Each player holds a request until it is granted. Grants are round-robin when both players request.
- Read data returns to the owning player after a fixed pipeline latency, tagged by requester.
- Sits between the per-player address logic and the single sprite ROM instance. Its output data feeds the colour mapping stage.

---
 rtl/sprite_fetch_arbiter.sv | 125 ++++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_arbiter.sv
// Sprite ROM read-port arbiter: two players share one ROM read port.
// Round-robin grant when both request; read data returns to the owner
// MEM_LAT+1 cycles after the grant, in issue order, steered by a tag pipeline.
//
//   state  | meaning
//   PRI_P1 | player 1 wins if both players request this cycle
//   PRI_P2 | player 2 wins if both players request this cycle
module sprite_fetch_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 24,
  parameter int MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  output logic              gnt2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid2,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [2:0]        inflight
);

  typedef enum logic {PRI_P1 = 1'b0, PRI_P2 = 1'b1} pri_e;

  pri_e               pri_q, pri_d;
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_id_q, tag_id_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d;
  logic [DATA_W-1:0]  rdata2_q, rdata2_d;
  logic               rvalid1_q, rvalid1_d;
  logic               rvalid2_q, rvalid2_d;
  logic [2:0]         inflight_q, inflight_d;
  logic               ret_vld;
  logic               ret_id;

  // Grant selection and priority pointer next state
  always_comb begin
    gnt1     = 1'b0;
    gnt2     = 1'b0;
    pri_d    = pri_q;
    if (req1 && (!req2 || pri_q == PRI_P1)) begin
      gnt1 = 1'b1;
    end else if (req2) begin
      gnt2 = 1'b1;
    end
    mem_rd   = gnt1 | gnt2;
    // Idle cycles still present addr1 so the ROM address is never X.
    mem_addr = gnt2 ? addr2 : addr1;
    if (gnt1) begin
      pri_d = PRI_P2;
    end else if (gnt2) begin
      pri_d = PRI_P1;
    end
  end

  // Tag pipeline shift: stage 0 captures this cycle's issue, last stage
  // lines up with mem_data being valid.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = mem_rd;
    tag_id_d[0]  = gnt2;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  assign ret_vld = tag_vld_q[MEM_LAT-1];
  assign ret_id  = tag_id_q[MEM_LAT-1];

  // Return steering and outstanding-read accounting
  always_comb begin
    rvalid1_d  = ret_vld & ~ret_id;
    rvalid2_d  = ret_vld & ret_id;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    inflight_d = inflight_q;
    if (rvalid1_d) rdata1_d = mem_data;
    if (rvalid2_d) rdata2_d = mem_data;
    if (mem_rd && !ret_vld) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!mem_rd && ret_vld) begin
      inflight_d = inflight_q - 3'd1;
    end
  end

  // State registers; reset drops every outstanding tag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pri_q      <= PRI_P1;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      rvalid1_q  <= 1'b0;
      rvalid2_q  <= 1'b0;
      inflight_q <= 3'd0;
    end else begin
      pri_q      <= pri_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      rvalid1_q  <= rvalid1_d;
      rvalid2_q  <= rvalid2_d;
      inflight_q <= inflight_d;
    end
  end

  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;
  assign rvalid1  = rvalid1_q;
  assign rvalid2  = rvalid2_q;
  assign inflight = inflight_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Bench for sprite_fetch_arbiter: three instances (MEM_LAT 2, 1, 4) share
// the same request stimulus; each has a ROM model returning addr as data and
// a scoreboard monitor checking grants, return order, latency and inflight.
module tb_sprite_fetch_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 24;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              req1 = 1'b0;
  logic              req2 = 1'b0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [ADDR_W-1:0] addr2 = '0;
  int                n_cmp = 0;
  int                n_mis = 0;
  int                cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic              gnt1, gnt2, rvalid1, rvalid2, mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rdata1, rdata2, mem_data;
    logic [2:0]        inflight;
    logic [DATA_W-1:0] rom_pipe [4];

    sprite_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(L)) dut (
      .Clk(Clk), .Reset(Reset),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
      .req2(req2), .addr2(addr2), .gnt2(gnt2), .rdata2(rdata2), .rvalid2(rvalid2),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .inflight(inflight)
    );

    // ROM model: data equals the address sampled L edges earlier
    always @(posedge Clk) begin
      rom_pipe[0] <= DATA_W'(mem_addr);
      for (int k = 1; k < 4; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign mem_data = rom_pipe[L-1];

    bit                exp_id_q [$];
    logic [DATA_W-1:0] exp_data_q [$];
    int                exp_cyc_q [$];
    bit                ptr_m = 1'b0;
    logic [DATA_W-1:0] rd1_m = '0;
    logic [DATA_W-1:0] rd2_m = '0;

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge Clk) begin
      bit e1, e2, pid;
      logic [DATA_W-1:0] pd;
      logic [ADDR_W-1:0] ea;
      int pc;
      if (Reset) begin
        exp_id_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
        ptr_m = 1'b0; rd1_m = '0; rd2_m = '0;
      end
      if (rvalid1 || rvalid2) begin
        n_cmp++;
        if (rvalid1 && rvalid2) begin
          n_mis++;
          $display("FAIL L=%0d dual_rvalid: both rvalid high at cycle %0d, required one", L, cyc);
        end else if (exp_id_q.size() == 0) begin
          n_mis++;
          $display("FAIL L=%0d unexpected_rvalid: rvalid1=%0b rvalid2=%0b at cycle %0d, required none", L, rvalid1, rvalid2, cyc);
        end else begin
          pid = exp_id_q.pop_front(); pd = exp_data_q.pop_front(); pc = exp_cyc_q.pop_front();
          if (pid !== rvalid2) begin
            n_mis++;
            $display("FAIL L=%0d return_id: got player %0d, required player %0d", L, rvalid2 ? 2 : 1, pid ? 2 : 1);
          end
          n_cmp++;
          if ((rvalid1 ? rdata1 : rdata2) !== pd) begin
            n_mis++;
            $display("FAIL L=%0d return_data: got %h, required %h", L, rvalid1 ? rdata1 : rdata2, pd);
          end
          n_cmp++;
          if (cyc !== pc + L + 1) begin
            n_mis++;
            $display("FAIL L=%0d latency: got %0d, required %0d", L, cyc - pc, L + 1);
          end
          if (pid) rd2_m = pd; else rd1_m = pd;
        end
      end
      n_cmp++;
      if (rdata1 !== rd1_m || rdata2 !== rd2_m) begin
        n_mis++;
        $display("FAIL L=%0d rdata_hold: got %h/%h, required %h/%h", L, rdata1, rdata2, rd1_m, rd2_m);
      end
      n_cmp++;
      if (inflight !== 3'(exp_id_q.size())) begin
        n_mis++;
        $display("FAIL L=%0d inflight: got %0d, required %0d", L, inflight, exp_id_q.size());
      end
      e1 = req1 && (!req2 || !ptr_m);
      e2 = req2 && !e1;
      ea = e2 ? addr2 : addr1;
      n_cmp++;
      if ({gnt1, gnt2, mem_rd} !== {e1, e2, e1 | e2} || mem_addr !== ea) begin
        n_mis++;
        $display("FAIL L=%0d grant: got g1=%0b g2=%0b rd=%0b addr=%h, required g1=%0b g2=%0b rd=%0b addr=%h",
                 L, gnt1, gnt2, mem_rd, mem_addr, e1, e2, e1 | e2, ea);
      end
      if (!Reset && (e1 || e2)) begin
        exp_id_q.push_back(e2);
        exp_data_q.push_back(DATA_W'(ea));
        exp_cyc_q.push_back(cyc);
        ptr_m = e1;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; req1 = 1'b0; req2 = 1'b0;
    repeat (3) step();
    Reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      n_cmp++;
      if ({g_inst[0].gnt1, g_inst[0].gnt2, g_inst[0].mem_rd, g_inst[0].rvalid1, g_inst[0].rvalid2,
           g_inst[0].inflight, g_inst[0].rdata1, g_inst[0].rdata2} !== '0) begin
        n_mis++;
        $display("FAIL reset_idle: cycle %0d got g1=%0b g2=%0b rd=%0b rv=%0b%0b infl=%0d rdata=%h/%h, required all zero",
                 n, g_inst[0].gnt1, g_inst[0].gnt2, g_inst[0].mem_rd, g_inst[0].rvalid1, g_inst[0].rvalid2,
                 g_inst[0].inflight, g_inst[0].rdata1, g_inst[0].rdata2);
      end
      step();
    end
  endtask

  task automatic test_single();
    int lat;
    req1 = 1'b1; addr1 = ADDR_W'(32'h00100);
    #1;
    n_cmp++;
    if (g_inst[0].gnt1 !== 1'b1 || g_inst[0].gnt2 !== 1'b0 || g_inst[0].mem_addr !== ADDR_W'(32'h00100)) begin
      n_mis++;
      $display("FAIL single_grant: got g1=%0b g2=%0b addr=%h, required g1=1 g2=0 addr=00100",
               g_inst[0].gnt1, g_inst[0].gnt2, g_inst[0].mem_addr);
    end
    step();
    req1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      if (g_inst[0].rvalid1) begin
        lat = n;
        break;
      end
      step();
    end
    n_cmp++;
    if (lat !== 3) begin
      n_mis++;
      $display("FAIL single_latency: got %0d cycles, required 3", lat);
    end
    n_cmp++;
    if (g_inst[0].rdata1 !== 24'h000100 || g_inst[0].rvalid2 !== 1'b0) begin
      n_mis++;
      $display("FAIL single_data: got rdata1=%h rvalid2=%0b, required 000100 and 0", g_inst[0].rdata1, g_inst[0].rvalid2);
    end
    repeat (6) step();
  endtask

  task automatic test_throughput();
    int a1 = 0;
    int a2 = 0;
    int pk0 = 0;
    int pk1 = 0;
    int pk2 = 0;
    bit e1;
    // start from a known pointer of player 1
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (n < 8) begin
        req1 = 1'b1; req2 = 1'b1;
        addr1 = ADDR_W'(32'h10 + a1);
        addr2 = ADDR_W'(32'h200 + a2);
      end else begin
        req1 = 1'b0; req2 = 1'b0;
      end
      #1;
      if (n < 8) begin
        e1 = (n % 2 == 0);
        n_cmp++;
        if ({g_inst[0].gnt1, g_inst[0].gnt2, g_inst[1].gnt1, g_inst[1].gnt2, g_inst[2].gnt1, g_inst[2].gnt2}
            !== {e1, !e1, e1, !e1, e1, !e1}) begin
          n_mis++;
          $display("FAIL alternate: cycle %0d got gnt %0b%0b/%0b%0b/%0b%0b, required %0b%0b",
                   n, g_inst[0].gnt1, g_inst[0].gnt2, g_inst[1].gnt1, g_inst[1].gnt2,
                   g_inst[2].gnt1, g_inst[2].gnt2, e1, !e1);
        end
        if (e1) a1++; else a2++;
      end
      if (int'(g_inst[0].inflight) > pk0) pk0 = int'(g_inst[0].inflight);
      if (int'(g_inst[1].inflight) > pk1) pk1 = int'(g_inst[1].inflight);
      if (int'(g_inst[2].inflight) > pk2) pk2 = int'(g_inst[2].inflight);
      step();
    end
    n_cmp++;
    if (pk0 !== 2 || pk1 !== 1 || pk2 !== 4) begin
      n_mis++;
      $display("FAIL inflight_peak: got %0d/%0d/%0d, required 2/1/4", pk0, pk1, pk2);
    end
  endtask

  task automatic test_pointer();
    // last grant of the throughput run went to player 2
    req1 = 1'b1; req2 = 1'b1; addr1 = ADDR_W'(32'h3000); addr2 = ADDR_W'(32'h4000);
    #1;
    n_cmp++;
    if (g_inst[0].gnt1 !== 1'b1 || g_inst[0].gnt2 !== 1'b0) begin
      n_mis++;
      $display("FAIL ptr_after_p2: got g1=%0b g2=%0b, required g1=1 g2=0", g_inst[0].gnt1, g_inst[0].gnt2);
    end
    step();
    req1 = 1'b0; req2 = 1'b0;
    step();
    req1 = 1'b1; req2 = 1'b1; addr1 = ADDR_W'(32'h3001);
    #1;
    n_cmp++;
    if (g_inst[0].gnt1 !== 1'b0 || g_inst[0].gnt2 !== 1'b1) begin
      n_mis++;
      $display("FAIL ptr_after_p1: got g1=%0b g2=%0b, required g1=0 g2=1", g_inst[0].gnt1, g_inst[0].gnt2);
    end
    step();
    // player 2 withdraws before a second grant; player 1 keeps the port
    req2 = 1'b0;
    step();
    req1 = 1'b0;
    repeat (7) step();
  endtask

  task automatic test_reset_midflight();
    req2 = 1'b1; addr2 = ADDR_W'(32'h5555);
    step();
    req2 = 1'b0; req1 = 1'b1; addr1 = ADDR_W'(32'h6666);
    step();
    req1 = 1'b0; Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      n_cmp++;
      if ({g_inst[0].rvalid1, g_inst[0].rvalid2, g_inst[1].rvalid1, g_inst[1].rvalid2,
           g_inst[2].rvalid1, g_inst[2].rvalid2} !== 6'b0 ||
          g_inst[0].inflight !== 3'd0 || g_inst[0].rdata1 !== '0 || g_inst[0].rdata2 !== '0) begin
        n_mis++;
        $display("FAIL flush: cycle %0d got rvalid %0b%0b infl=%0d rdata=%h/%h, required all zero",
                 n, g_inst[0].rvalid1, g_inst[0].rvalid2, g_inst[0].inflight, g_inst[0].rdata1, g_inst[0].rdata2);
      end
      step();
    end
    req1 = 1'b1; req2 = 1'b1;
    #1;
    n_cmp++;
    if (g_inst[0].gnt1 !== 1'b1 || g_inst[0].gnt2 !== 1'b0) begin
      n_mis++;
      $display("FAIL ptr_reset: got g1=%0b g2=%0b, required g1=1 g2=0", g_inst[0].gnt1, g_inst[0].gnt2);
    end
    step();
    req1 = 1'b0; req2 = 1'b0;
    repeat (7) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_throughput();
    test_pointer();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
